arm_regfile_write_arbiter: RTL
==============================

// Module: arm_regfile_write_arbiter
// PURPOSE
// - Shares the single register-file write port between two writers.
// - Writer A is the pipeline writeback stage. It always has priority and is never back-pressured.
// - Writer B is a long-latency unit (multiplier). Its results are buffered in a FIFO and drained into idle write slots.
// - The block also exports a pending-register mask for the hazard unit and a stall request that prevents starvation of writer B.
// PARAMETERS
// - BusWidth      32  data width of the write port
// - RegAddrWidth  4   register address width; R15 (4'hF) is the PC and is not writable here
// - FifoDepth     2   writer-B buffer entries (>=1)
// - StarveLimit   4   number of cycles the FIFO head may wait before o_Stall asserts (>=1)
// PORTS
// - i_CLK            in   1             clock; all state changes on the rising edge
// - i_RESET          in   1             synchronous, active-high reset
// - i_WB_Valid       in   1             writeback write request this cycle
// - i_WB_Addr        in   RegAddrWidth  writeback destination register
// - i_WB_Data        in   BusWidth      writeback data
// - i_MUL_Valid      in   1             writer-B result valid
// - o_MUL_Ready      out  1             writer B may push this cycle
// - i_MUL_Addr       in   RegAddrWidth  writer-B destination register
// - i_MUL_Data       in   BusWidth      writer-B data
// - o_WriteEnable    out  1             register-file write enable (registered)
// - o_WriteAddr      out  RegAddrWidth  register-file write address (registered)
// - o_WriteData      out  BusWidth      register-file write data (registered)
// - o_PendingMask    out  15            bit r set = register r has a buffered writer-B entry
// - o_Stall          out  1             request: pipeline holds i_WB_Valid low so the FIFO can drain
// - o_R15_Drop       out  1             one-cycle pulse: a write to R15 was discarded
// BEHAVIOUR
// - Reset (i_RESET=1 at an edge): FIFO emptied, starve counter=0.
//   - All registered outputs become 0, and o_MUL_Ready=0 while i_RESET is high.
//   - A reset mid-drain discards buffered entries; no partial write is issued.
// - Handshake: a writer-B push occurs when i_MUL_Valid && o_MUL_Ready.
//   - o_MUL_Ready = !i_RESET && (count < FifoDepth), using the registered count.
//   - A full FIFO does not accept a push even in a cycle in which it pops.
// - Arbitration, evaluated each cycle; the result appears on o_Write* at the next edge (1-cycle latency):
//   - 1. i_WB_Valid && i_WB_Addr!=4'hF: issue the WB write; the FIFO holds.
//   - 2. Otherwise, if the FIFO is non-empty: pop the head and issue it.
//   - 3. Otherwise: o_WriteEnable=0.
//   - The WB write always wins, including while o_Stall=1 (protocol violation, but no data loss).
// - R15: WB with addr 4'hF is not issued; the slot counts as free for a FIFO pop.
//   - A writer-B push with addr 4'hF is accepted (handshake completes) but not stored.
//   - Either case pulses o_R15_Drop for one cycle, starting the next edge. If both occur in one cycle, a single pulse is produced.
// - FIFO: circular, in-order, with wrap-around read/write pointers.
//   - Simultaneous push and pop when count < FifoDepth leaves count unchanged.
//   - Bypass from the push port directly to the write port: none. A push reaches the write port no earlier than 2 cycles later.
// - o_PendingMask is combinational from registered state: the OR of the one-hot decoded addresses of all valid FIFO entries. It clears when an entry pops, not when the register file is written.
// - Starve counter:
//   - Increments (saturating at StarveLimit) each cycle the FIFO is non-empty and does not pop.
//   - Clears on a pop or when the FIFO is empty.
//   - o_Stall = (counter == StarveLimit), registered.
// - Same-register ordering between the WB and writer-B paths is not enforced here; the last issued write wins. The hazard unit uses o_PendingMask to prevent conflicts.
// TESTING
// - Reset:
//   - Stimulus: hold i_RESET=1 for 2 cycles with i_MUL_Valid=1.
//   - Required: o_MUL_Ready=0, all outputs 0, no push.
//   - After release: o_MUL_Ready=1, o_PendingMask=0.
// - WB only:
//   - Stimulus: i_WB_Valid=1, addr=3, data=32'hA5A5_0001.
//   - Required: next cycle o_WriteEnable=1, o_WriteAddr=3, o_WriteData=32'hA5A5_0001.
// - Buffer and drain:
//   - Stimulus: push MUL (addr 5, 32'h11) and (addr 6, 32'h22) while WB is busy every cycle.
//   - Required while WB is busy: o_MUL_Ready=0 after the 2nd push, and o_PendingMask=15'h0060.
//   - Stimulus: release WB.
//   - Required: writes of 5 then 6 on consecutive cycles, then the mask returns to 0.
// - Starvation:
//   - Stimulus: one FIFO entry with WB busy continuously.
//   - Required: o_Stall=1 after 4 waiting cycles.
//   - Stimulus: drop WB for 1 cycle.
//   - Required: the entry pops, and o_Stall=0 the following cycle.
// - R15 drop:
//   - Stimulus: WB addr 4'hF, and separately MUL addr 4'hF.
//   - Required: no write issued, one-cycle o_R15_Drop pulse each, FIFO count unchanged.
// - Reset mid-drain:
//   - Stimulus: assert i_RESET with the FIFO full.
//   - Required: next cycle o_WriteEnable=0 and mask=0, with no stale writes after release.

Source files
------------

// File: rtl/arm_regfile_write_arbiter.sv
// arm_regfile_write_arbiter
//   Shares the single register-file write port between the pipeline writeback
//   stage (writer A, always wins, never back-pressured) and a long-latency
//   unit such as the multiplier (writer B). Writer-B results are held in a
//   small circular FIFO and drained into slots that writeback leaves idle.
//
// Ports
//   i_CLK, i_RESET                      clock, synchronous active-high reset
//   i_WB_Valid/Addr/Data                writeback write request
//   i_MUL_Valid/Addr/Data, o_MUL_Ready  writer-B push handshake
//   o_WriteEnable/Addr/Data             registered register-file write port
//   o_PendingMask                       bit r = register r buffered in the FIFO
//   o_Stall                             asks the pipeline to idle writeback
//   o_R15_Drop                          one-cycle pulse: a write to R15 was dropped
module arm_regfile_write_arbiter #(
    parameter int BusWidth     = 32,
    parameter int RegAddrWidth = 4,
    parameter int FifoDepth    = 2,
    parameter int StarveLimit  = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET,
    input  logic                    i_WB_Valid,
    input  logic [RegAddrWidth-1:0] i_WB_Addr,
    input  logic [BusWidth-1:0]     i_WB_Data,
    input  logic                    i_MUL_Valid,
    output logic                    o_MUL_Ready,
    input  logic [RegAddrWidth-1:0] i_MUL_Addr,
    input  logic [BusWidth-1:0]     i_MUL_Data,
    output logic                    o_WriteEnable,
    output logic [RegAddrWidth-1:0] o_WriteAddr,
    output logic [BusWidth-1:0]     o_WriteData,
    output logic [14:0]             o_PendingMask,
    output logic                    o_Stall,
    output logic                    o_R15_Drop
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int StvW = $clog2(StarveLimit + 1);

    localparam logic [RegAddrWidth-1:0] AddrR15  = '1;
    localparam logic [CntW-1:0]         CntFull  = CntW'(FifoDepth);
    localparam logic [StvW-1:0]         StvMax   = StvW'(StarveLimit);
    localparam logic [PtrW:0]           SlotWrap = (PtrW + 1)'(FifoDepth);

    logic [RegAddrWidth-1:0] fifo_addr [FifoDepth];
    logic [BusWidth-1:0]     fifo_data [FifoDepth];
    logic [PtrW-1:0]         rd_ptr;
    logic [PtrW-1:0]         wr_ptr;
    logic [CntW-1:0]         count;
    logic [StvW-1:0]         starve_cnt;
    logic [StvW-1:0]         starve_next;

    logic fifo_empty;
    logic wb_issue;
    logic fifo_pop;
    logic mul_push;
    logic mul_store;
    logic r15_drop;
    logic [PtrW:0] slot;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign fifo_empty  = (count == '0);
    assign wb_issue    = i_WB_Valid && (i_WB_Addr != AddrR15);
    // An R15 writeback leaves the slot free, so the FIFO may drain into it.
    assign fifo_pop    = !wb_issue && !fifo_empty;
    // Ready depends only on the registered count: a full FIFO refuses a push
    // even in a cycle where it also pops.
    assign o_MUL_Ready = !i_RESET && (count != CntFull);
    assign mul_push    = i_MUL_Valid && o_MUL_Ready;
    // R15 pushes complete the handshake but are never stored.
    assign mul_store   = mul_push && (i_MUL_Addr != AddrR15);
    assign r15_drop    = (i_WB_Valid && (i_WB_Addr == AddrR15)) ||
                         (mul_push && (i_MUL_Addr == AddrR15));

    always_comb begin
        starve_next = '0;
        if (!fifo_empty && !fifo_pop) begin
            starve_next = (starve_cnt == StvMax) ? StvMax : starve_cnt + StvW'(1);
        end
    end

    // Walk the valid entries from the head; stored addresses are never R15.
    always_comb begin
        o_PendingMask = '0;
        slot          = '0;
        for (int k = 0; k < FifoDepth; k++) begin
            if (CntW'(k) < count) begin
                slot = {1'b0, rd_ptr} + (PtrW + 1)'(k);
                if (slot >= SlotWrap) begin
                    slot = slot - SlotWrap;
                end
                for (int r = 0; r < 15; r++) begin
                    if (fifo_addr[slot[PtrW-1:0]] == RegAddrWidth'(r)) begin
                        o_PendingMask[r] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (mul_store) begin
            fifo_addr[wr_ptr] <= i_MUL_Addr;
            fifo_data[wr_ptr] <= i_MUL_Data;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            starve_cnt    <= '0;
            o_Stall       <= 1'b0;
            o_R15_Drop    <= 1'b0;
            o_WriteEnable <= 1'b0;
            o_WriteAddr   <= '0;
            o_WriteData   <= '0;
        end else begin
            if (mul_store) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (fifo_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count      <= count + CntW'(mul_store) - CntW'(fifo_pop);
            starve_cnt <= starve_next;
            o_Stall    <= (starve_next == StvMax);
            o_R15_Drop <= r15_drop;

            if (wb_issue) begin
                o_WriteEnable <= 1'b1;
                o_WriteAddr   <= i_WB_Addr;
                o_WriteData   <= i_WB_Data;
            end else if (fifo_pop) begin
                o_WriteEnable <= 1'b1;
                o_WriteAddr   <= fifo_addr[rd_ptr];
                o_WriteData   <= fifo_data[rd_ptr];
            end else begin
                o_WriteEnable <= 1'b0;
            end
        end
    end

endmodule
